// File: rtl/sn74xx594_shreg_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sn74xx594_shreg_gen                                        |
// | Description : WIDTH-bit bidirectional shift register with parallel load  |
// |               feeding a WIDTH-bit output register (74LS594 successor).   |
// |               Optional auto-transfer after WIDTH shifts is enabled by    |
// |               defining the macro SN74XX594_AUTOLATCH_EN.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sn74xx594_shreg_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             rclr,
    input  logic [1:0]       mode,
    input  logic             ser_up,
    input  logic             ser_dn,
    input  logic [WIDTH-1:0] d,
    input  logic             rck_en,
    output logic [WIDTH-1:0] q,
    output logic             qh,
    output logic             ql,
    output logic             done
);

    localparam logic [1:0] c_MODE_HOLD = 2'b00;
    localparam logic [1:0] c_MODE_UP   = 2'b01;
    localparam logic [1:0] c_MODE_DN   = 2'b10;
    localparam logic [1:0] c_MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_q;
    logic             w_pending;
    logic             w_xfer;

    // Shift register: master clear, then local clear, then mode.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_sr <= '0;
        end else if (!sclr) begin
            r_sr <= '0;
        end else begin
            case (mode)
                c_MODE_UP:   r_sr <= {r_sr[WIDTH-2:0], ser_up};
                c_MODE_DN:   r_sr <= {ser_dn, r_sr[WIDTH-1:1]};
                c_MODE_LOAD: r_sr <= d;
                c_MODE_HOLD: r_sr <= r_sr;
                default:     r_sr <= r_sr;
            endcase
        end
    end

    always_comb w_xfer = rck_en | w_pending;

    // Output register always captures the pre-edge shift register contents.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_q <= '0;
        end else if (!rclr) begin
            r_q <= '0;
        end else if (w_xfer) begin
            r_q <= r_sr;
        end
    end

    assign q  = r_q;
    assign qh = r_sr[WIDTH-1];
    assign ql = r_sr[0];

`ifdef SN74XX594_AUTOLATCH_EN
    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               r_pending;
    logic               r_done;
    logic               w_shift;

    always_comb w_shift = (mode == c_MODE_UP) || (mode == c_MODE_DN);

    // pending lives for one cycle; the transfer it requests happens on the
    // following edge regardless of what that edge does to the count.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_count   <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= r_pending & rclr;
            if (!sclr || (mode == c_MODE_LOAD)) begin
                r_count   <= '0;
                r_pending <= 1'b0;
            end else if (w_shift) begin
                if (r_count == c_LAST) begin
                    r_count   <= '0;
                    r_pending <= 1'b1;
                end else begin
                    r_count   <= r_count + c_CNT_W'(1);
                    r_pending <= 1'b0;
                end
            end else begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_pending = r_pending;
    assign done      = r_done;
`else
    assign w_pending = 1'b0;
    assign done      = 1'b0;
`endif

endmodule
`default_nettype wire
